logic_unit_arbiter: RTL

- Shares one registered bitwise logic unit (AND/OR/XOR/AND-NOT) between NREQ requesters.
- Uses round-robin arbitration with a valid/ready handshake on every requester port and on the result port.
- The result is registered, tagged with the winning requester's index, and held under backpressure.
- Sits between the client blocks and the synchronous bitwise datapath, and replaces the per-client copies of that datapath.

---
 rtl/logic_unit_arbiter.sv | 88 ++++++++
 1 files changed

// File: rtl/logic_unit_arbiter.sv
// Round-robin shared bitwise logic unit (AND/OR/XOR/ANDN) for NREQ requesters, result tagged with winner id.
// Latency 1 cycle, 1 op/cycle; res_ready low holds the result and drops every req_ready.
module logic_unit_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4,
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*2-1:0]     req_op,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH-1:0]      res_data,
    output logic [ID_W-1:0]       res_id
);

    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  win;
    logic [ID_W-1:0]  ptr_next;
    logic             found;
    logic             can_accept;
    logic             accept;
    logic [WIDTH-1:0] a_w;
    logic [WIDTH-1:0] b_w;
    logic [1:0]       op_w;
    logic [WIDTH-1:0] op_res;
    int               idx;

    assign can_accept = !res_valid || res_ready;

    // First valid requester at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (found && can_accept) req_ready[win] = 1'b1;
    end

    assign accept   = found && can_accept;
    assign ptr_next = (win == ID_W'(NREQ - 1)) ? '0 : win + 1'b1;

    assign a_w  = req_a[int'(win)*WIDTH +: WIDTH];
    assign b_w  = req_b[int'(win)*WIDTH +: WIDTH];
    assign op_w = req_op[int'(win)*2 +: 2];

    always_comb begin
        case (op_w)
            2'b00:   op_res = a_w & b_w;
            2'b01:   op_res = a_w | b_w;
            2'b10:   op_res = a_w ^ b_w;
            default: op_res = a_w & ~b_w;
        endcase
    end

    // A new accept overwrites a result leaving on the same edge, so no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            ptr       <= '0;
        end else if (accept) begin
            res_valid <= 1'b1;
            res_data  <= op_res;
            res_id    <= win;
            ptr       <= ptr_next;
        end else if (res_ready) begin
            res_valid <= 1'b0;
        end
    end

endmodule
